// File: rtl/led_seq_ctrl.sv
// Run/pause/single-step sequencer for the two-LED Gray-code pattern.
// Raw buttons are synchronised and debounced; p is synchronised only.
module led_seq_ctrl #(
   parameter int STEP_CYCLES     = 50_000_000,
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int TIMER_W         = 31
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       p,
   input  logic       run_btn,
   input  logic       step_btn,
   output logic [1:0] Led,
   output logic [1:0] pos,
   output logic       running,
   output logic       step_tick
);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      PAUSE
   } state_t;

   localparam logic [TIMER_W-1:0] STEP_LAST = TIMER_W'(STEP_CYCLES - 1);
   localparam logic [TIMER_W-1:0] DB_LAST   = TIMER_W'(DEBOUNCE_CYCLES - 1);

   // Bit 0 = p, bit 1 = run_btn, bit 2 = step_btn.
   logic [2:0]         sync1;
   logic [2:0]         sync2;

   // Button index 0 = run, 1 = step.
   logic [1:0]         btn_smp;
   logic [1:0]         btn_lvl;
   logic [1:0]         btn_lvl_q;
   logic [1:0]         btn_evt;
   logic [TIMER_W-1:0] db_cnt [2];

   state_t             state;
   logic [TIMER_W-1:0] timer;
   logic               dir;
   logic               run_evt;
   logic               step_evt;
   logic [1:0]         pos_adv;

   function automatic logic [1:0] pattern(input logic [1:0] ps);
      logic [1:0] led;
      unique case (ps)
         2'd0:    led = 2'b11;
         2'd1:    led = 2'b01;
         2'd2:    led = 2'b00;
         default: led = 2'b10;
      endcase
      return led;
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= {step_btn, run_btn, p};
         sync2 <= sync1;
      end
   end

   assign dir     = sync2[0];
   assign btn_smp = sync2[2:1];

   // Press events come from the registered level so they trail the flip by one edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         btn_lvl   <= '0;
         btn_lvl_q <= '0;
         btn_evt   <= '0;
         for (int unsigned i = 0; i < 2; i++) begin
            db_cnt[i] <= '0;
         end
      end else begin
         btn_lvl_q <= btn_lvl;
         btn_evt   <= btn_lvl & ~btn_lvl_q;
         for (int unsigned i = 0; i < 2; i++) begin
            if (btn_smp[i] != btn_lvl[i]) begin
               if (db_cnt[i] == DB_LAST) begin
                  btn_lvl[i] <= btn_smp[i];
                  db_cnt[i]  <= '0;
               end else begin
                  db_cnt[i] <= db_cnt[i] + 1'b1;
               end
            end else begin
               db_cnt[i] <= '0;
            end
         end
      end
   end

   assign run_evt  = btn_evt[0];
   assign step_evt = btn_evt[1];
   assign pos_adv  = dir ? pos + 2'd1 : pos - 2'd1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         timer     <= '0;
         pos       <= '0;
         Led       <= 2'b11;
         running   <= 1'b0;
         step_tick <= 1'b0;
      end else begin
         step_tick <= 1'b0;
         unique case (state)
            IDLE: begin
               if (run_evt) begin
                  state   <= RUN;
                  running <= 1'b1;
                  timer   <= '0;
               end
            end
            RUN: begin
               if (run_evt) begin
                  state   <= PAUSE;
                  running <= 1'b0;
               end else if (timer == STEP_LAST) begin
                  timer     <= '0;
                  pos       <= pos_adv;
                  Led       <= pattern(pos_adv);
                  step_tick <= 1'b1;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            PAUSE: begin
               // A run event in the same cycle as a step swallows the step.
               if (run_evt) begin
                  state   <= RUN;
                  running <= 1'b1;
                  timer   <= '0;
               end else if (step_evt) begin
                  pos       <= pos_adv;
                  Led       <= pattern(pos_adv);
                  step_tick <= 1'b1;
               end
            end
            default: begin
               state   <= IDLE;
               running <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Bench for led_seq_ctrl: directed vector table plus randomized buttons
// checked every cycle against a behavioural model.
module tb_led_seq_ctrl;

   localparam int STEP = 8;
   localparam int DB   = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       p = 1'b1;
   logic       run_btn = 1'b0;
   logic       step_btn = 1'b0;
   logic [1:0] Led;
   logic [1:0] pos;
   logic       running;
   logic       step_tick;

   led_seq_ctrl #(
      .STEP_CYCLES(STEP),
      .DEBOUNCE_CYCLES(DB),
      .TIMER_W(4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .p(p),
      .run_btn(run_btn),
      .step_btn(step_btn),
      .Led(Led),
      .pos(pos),
      .running(running),
      .step_tick(step_tick)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit         rst;
      bit         p;
      bit         run;
      bit         stp;
      int         cyc;
      logic [1:0] led;
      logic [1:0] pos;
      bit         running;
      bit         tick;
      string      name;
   } vec_t;

   vec_t       tbl[$];
   int         errors = 0;
   int         checks = 0;
   logic [1:0] pat [4] = '{2'b11, 2'b01, 2'b00, 2'b10};

   // Behavioural model state.
   bit m_s1 [3];
   bit m_s2 [3];
   bit m_lvl [2];
   bit m_rose [2];
   bit m_evt [2];
   bit hist_run[$];
   bit hist_step[$];
   int m_mode;   // 0 idle, 1 run, 2 pause
   int m_phase;  // clocks elapsed in the current run period
   int m_pos;
   bit m_tick;

   function automatic void model_reset();
      for (int i = 0; i < 3; i++) begin
         m_s1[i] = 1'b0;
         m_s2[i] = 1'b0;
      end
      for (int i = 0; i < 2; i++) begin
         m_lvl[i]  = 1'b0;
         m_rose[i] = 1'b0;
         m_evt[i]  = 1'b0;
      end
      hist_run.delete();
      hist_step.delete();
      m_mode  = 0;
      m_phase = 0;
      m_pos   = 0;
      m_tick  = 1'b0;
   endfunction

   function automatic void model_advance(input bit dir);
      m_pos  = (m_pos + (dir ? 1 : 3)) % 4;
      m_tick = 1'b1;
   endfunction

   // One rising edge, computed from the values visible before it.
   function automatic void model_edge();
      bit ev_run, ev_step, dir, smp_run, smp_step;
      if (rst) begin
         model_reset();
         return;
      end
      ev_run   = m_evt[0];
      ev_step  = m_evt[1];
      dir      = m_s2[0];
      smp_run  = m_s2[1];
      smp_step = m_s2[2];
      m_tick   = 1'b0;

      if (m_mode == 0) begin
         if (ev_run) begin
            m_mode  = 1;
            m_phase = 0;
         end
      end else if (m_mode == 1) begin
         if (ev_run) begin
            m_mode = 2;
         end else begin
            m_phase++;
            if (m_phase == STEP) begin
               m_phase = 0;
               model_advance(dir);
            end
         end
      end else begin
         if (ev_run) begin
            m_mode  = 1;
            m_phase = 0;
         end else if (ev_step) begin
            model_advance(dir);
         end
      end

      m_evt[0]  = m_rose[0];
      m_evt[1]  = m_rose[1];
      m_rose[0] = 1'b0;
      m_rose[1] = 1'b0;

      // A level is accepted after DB consecutive disagreeing samples.
      if (smp_run != m_lvl[0]) hist_run.push_back(smp_run);
      else hist_run.delete();
      if (hist_run.size() == DB) begin
         m_lvl[0]  = smp_run;
         m_rose[0] = smp_run;
         hist_run.delete();
      end
      if (smp_step != m_lvl[1]) hist_step.push_back(smp_step);
      else hist_step.delete();
      if (hist_step.size() == DB) begin
         m_lvl[1]  = smp_step;
         m_rose[1] = smp_step;
         hist_step.delete();
      end

      m_s2    = m_s1;
      m_s1[0] = p;
      m_s1[1] = run_btn;
      m_s1[2] = step_btn;
   endfunction

   task automatic check_model();
      bit exp_run;
      exp_run = (m_mode == 1);
      checks++;
      if (Led !== pat[m_pos] || pos !== 2'(m_pos) || running !== exp_run || step_tick !== m_tick) begin
         errors++;
         $display("FAIL model t=%0t: got Led=%b pos=%0d running=%b tick=%b, expected Led=%b pos=%0d running=%b tick=%b",
                  $time, Led, pos, running, step_tick, pat[m_pos], m_pos, exp_run, m_tick);
      end
   endtask

   // Called at a falling edge: drive inputs, then run cyc clocks checking each one.
   task automatic apply(input bit r, input bit pp, input bit rb, input bit sb, input int cyc);
      rst      = r;
      p        = pp;
      run_btn  = rb;
      step_btn = sb;
      if (r) model_reset();
      #1;
      if (r) check_model();
      for (int n = 0; n < cyc; n++) begin
         model_edge();
         @(posedge clk);
         @(negedge clk);
         check_model();
      end
   endtask

   function automatic void add(input bit r, input bit pp, input bit rb, input bit sb, input int cyc,
                               input logic [1:0] led, input logic [1:0] ps, input bit rn, input bit tk,
                               input string nm);
      vec_t v;
      v.rst = r; v.p = pp; v.run = rb; v.stp = sb; v.cyc = cyc;
      v.led = led; v.pos = ps; v.running = rn; v.tick = tk; v.name = nm;
      tbl.push_back(v);
   endfunction

   initial begin
      //  rst p run stp cyc   Led    pos running tick
      add(1, 1, 0, 0,   2, 2'b11, 2'd0, 0, 0, "reset");
      add(0, 1, 0, 0, 100, 2'b11, 2'd0, 0, 0, "idle");
      add(0, 1, 1, 0,   7, 2'b11, 2'd0, 0, 0, "run_latency");
      add(0, 1, 1, 0,   1, 2'b11, 2'd0, 1, 0, "run_rise");
      add(0, 1, 0, 0,   7, 2'b11, 2'd0, 1, 0, "first_period");
      add(0, 1, 0, 0,   1, 2'b01, 2'd1, 1, 1, "adv_pos1");
      add(0, 1, 0, 0,   1, 2'b01, 2'd1, 1, 0, "tick_single");
      add(0, 1, 0, 0,   7, 2'b00, 2'd2, 1, 1, "adv_pos2");
      add(0, 0, 0, 0,   3, 2'b00, 2'd2, 1, 0, "dir_change_mid");
      add(0, 0, 0, 0,   5, 2'b01, 2'd1, 1, 1, "rev_pos1");
      add(0, 0, 0, 0,   8, 2'b11, 2'd0, 1, 1, "rev_pos0");
      add(0, 0, 0, 0,   8, 2'b10, 2'd3, 1, 1, "rev_wrap3");
      add(0, 0, 0, 0,   2, 2'b10, 2'd3, 1, 0, "gap");
      add(0, 0, 1, 0,   7, 2'b00, 2'd2, 1, 0, "pause_latency");
      add(0, 0, 1, 0,   1, 2'b00, 2'd2, 0, 0, "pause_enter");
      add(0, 0, 0, 0,  10, 2'b00, 2'd2, 0, 0, "pause_hold");
      add(0, 0, 0, 1,   7, 2'b00, 2'd2, 0, 0, "step_latency");
      add(0, 0, 0, 1,   1, 2'b01, 2'd1, 0, 1, "step1");
      add(0, 0, 0, 0,  10, 2'b01, 2'd1, 0, 0, "step1_release");
      add(0, 0, 0, 1,   8, 2'b11, 2'd0, 0, 1, "step2");
      add(0, 0, 0, 0,  10, 2'b11, 2'd0, 0, 0, "step2_release");
      add(0, 0, 0, 1,   8, 2'b10, 2'd3, 0, 1, "step3_wrap");
      add(0, 0, 0, 0,  10, 2'b10, 2'd3, 0, 0, "step3_release");
      add(0, 0, 0, 1,   3, 2'b10, 2'd3, 0, 0, "glitch");
      add(0, 0, 0, 0,   8, 2'b10, 2'd3, 0, 0, "glitch_no_event");
      for (int i = 0; i < 5; i++) begin
         add(0, 0, 1, 0, 2, 2'b10, 2'd3, 0, 0, "bounce_hi");
         add(0, 0, 0, 0, 2, 2'b10, 2'd3, 0, 0, "bounce_lo");
      end
      add(0, 0, 1, 0,   7, 2'b10, 2'd3, 0, 0, "bounce_latency");
      add(0, 0, 1, 0,   1, 2'b10, 2'd3, 1, 0, "bounce_one_event");
      add(0, 0, 0, 0,   7, 2'b10, 2'd3, 1, 0, "resume_period");
      add(0, 0, 0, 0,   1, 2'b00, 2'd2, 1, 1, "resume_adv");
      add(0, 0, 0, 0,   2, 2'b00, 2'd2, 1, 0, "gap2");
      add(0, 0, 1, 0,   7, 2'b01, 2'd1, 1, 0, "pause2_latency");
      add(0, 0, 1, 0,   1, 2'b01, 2'd1, 0, 0, "pause2_enter");
      add(0, 0, 0, 0,  10, 2'b01, 2'd1, 0, 0, "pause2_hold");
      add(0, 0, 1, 1,   7, 2'b01, 2'd1, 0, 0, "both_latency");
      add(0, 0, 1, 1,   1, 2'b01, 2'd1, 1, 0, "both_run_wins");
      add(0, 0, 0, 0,   5, 2'b01, 2'd1, 1, 0, "timer_at5");
      add(1, 0, 0, 0,   0, 2'b11, 2'd0, 0, 0, "async_reset");
      add(1, 0, 0, 0,   2, 2'b11, 2'd0, 0, 0, "reset_hold");
      add(0, 0, 0, 0,  20, 2'b11, 2'd0, 0, 0, "idle_after_reset");

      model_reset();
      @(negedge clk);
      foreach (tbl[i]) begin
         apply(tbl[i].rst, tbl[i].p, tbl[i].run, tbl[i].stp, tbl[i].cyc);
         checks++;
         if (Led !== tbl[i].led || pos !== tbl[i].pos || running !== tbl[i].running || step_tick !== tbl[i].tick) begin
            errors++;
            $display("FAIL row %s: got Led=%b pos=%0d running=%b tick=%b, expected Led=%b pos=%0d running=%b tick=%b",
                     tbl[i].name, Led, pos, running, step_tick, tbl[i].led, tbl[i].pos, tbl[i].running, tbl[i].tick);
         end
      end

      for (int i = 0; i < 300; i++) begin
         bit r, pp, rb, sb;
         int cyc;
         r   = ($urandom_range(0, 39) == 0);
         pp  = ($urandom_range(0, 1) == 1);
         rb  = ($urandom_range(0, 9) < 3);
         sb  = ($urandom_range(0, 9) < 5);
         cyc = int'($urandom_range(1, 12));
         apply(r, pp, rb, sb, cyc);
      end
      apply(0, 1, 0, 0, 10);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/led_seq_ctrl.md
# led_seq_ctrl

Run/pause/single-step controller for the board's two-LED rotating pattern. Takes a raw run button, a raw step button and the direction switch `p`, debounces them, and sequences a 4-position Gray-code pattern onto `Led[1:0]` at a programmable step period. Sits directly between the board I/O pins and the LEDs, and replaces free-running pattern counters with an explicit state machine.

## Interface
- `STEP_CYCLES`, default 50_000_000: clocks per pattern step in RUN (1 s at 50 MHz); must be ≥ 2.
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive stable synchronised samples required to accept a button level change; must be ≥ 1.
- `TIMER_W`, default 31: width of the step timer and the debounce counters; must hold `STEP_CYCLES-1` and `DEBOUNCE_CYCLES-1`.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `p`  in  1  direction switch, asynchronous: 1 = forward, 0 = reverse.
- `run_btn`  in  1  raw run/pause pushbutton, active-high, asynchronous and bouncy.
- `step_btn`  in  1  raw single-step pushbutton, active-high, asynchronous and bouncy.
- `Led`  out  2  pattern output, registered.
- `pos`  out  2  current pattern position, registered.
- `running`  out  1  high while in RUN, registered.
- `step_tick`  out  1  one-cycle pulse on every position change, registered.

## Operation
- **Pattern:** `Led` always equals the pattern for the current `pos`.
  - pos0 = 2'b11, pos1 = 2'b01, pos2 = 2'b00, pos3 = 2'b10.
  - Forward (`p`=1) is `pos+1` mod 4; reverse (`p`=0) is `pos-1` mod 4. Both wrap (3→0 and 0→3).
- **Input synchronisation:** `p`, `run_btn` and `step_btn` each pass through a 2-flop synchroniser. `p` is not debounced.
- **Debounce (per button):**
  - The counter increments while the synchronised input differs from the debounced level, and clears when they match.
  - When the counter is at `DEBOUNCE_CYCLES-1` and the inputs still differ, the debounced level flips on the next edge and the counter clears.
  - A registered press event pulses for one cycle after each 0→1 debounced transition. Releases generate no event.
- **FSM states:** IDLE, RUN, PAUSE.
  - IDLE: run event → RUN. Step events are ignored.
  - RUN: the timer counts 0..`STEP_CYCLES-1`. On the terminal count the timer returns to 0 and `pos` advances in the current synchronised direction. Run event → PAUSE, with the timer holding its value. Step events are ignored.
  - PAUSE: run event → RUN, with the timer cleared to 0. Step event advances `pos` by one in the current direction and the timer is untouched.
  - Run and step events in the same cycle in PAUSE: run wins, the step is dropped, and `pos` is unchanged.
- **Direction changes:** direction is sampled only at the advance edge. A change mid-period takes effect at the next advance, and `pos` is never reset by a direction change.
- **Step tick:** `step_tick` is high for exactly the cycle in which the new `pos`/`Led` value is first visible.

## Timing
- **Reset values** (asynchronous, effective immediately, including mid-step or mid-debounce):
  - outputs: `Led`=2'b11, `pos`=0, `running`=0, `step_tick`=0;
  - internal: state IDLE, timer 0, debounce counters 0, debounced levels 0, synchronisers 0.
- **Button latency:** a raw press that is stable from before edge k changes state/`pos` at edge k+`DEBOUNCE_CYCLES`+3:
  - 2 edges in the synchroniser;
  - `DEBOUNCE_CYCLES` edges to flip the debounced level;
  - 1 edge for the event register;
  - 1 edge for the FSM update.
- **RUN period:** advances are exactly `STEP_CYCLES` clocks apart. The first advance after entering RUN comes `STEP_CYCLES` edges after the entry edge.
- **State outputs:** `running` rises and falls on the same edge as the state change.
- **Single step:** `Led`, `pos` and `step_tick` update together on the FSM edge; no extra output stage.
- **Glitches:** a bounce shorter than `DEBOUNCE_CYCLES` synchronised cycles produces no event.

## Test plan
All scenarios use `STEP_CYCLES`=8 and `DEBOUNCE_CYCLES`=4.
1. Reset released with buttons idle for 100 cycles → `Led`=11, `pos`=0, `running`=0, `step_tick` never pulses.
2. Clean run press, `p`=1 → `running` rises 7 edges after the press. `Led` then goes 01, 00, 10, 11, 01, … every 8 clocks, with one `step_tick` per change.
3. In RUN, `p` is switched to 0 while `pos`=2 mid-period → the next advance is to `pos`=1 (`Led`=01), then 0, then 3. Period stays at 8.
4. Run press in RUN → PAUSE. Three step presses with `p`=0 starting from `pos`=1 → `pos` goes 0, 3, 2. Each press gives one `step_tick` and no timer advances.
5. Bouncy run press (toggling every 2 cycles for 20 cycles, then held) → exactly one run event. A 3-cycle glitch on `step_btn` → no event.
6. Simultaneous run and step events in PAUSE → RUN entered, `pos` unchanged. Assert `rst` mid-RUN at timer=5 → outputs take their reset values before the next edge and the state is IDLE.
